gp01_acc_delta_decoder: RTL and testbench
=========================================

// Module: gp01_acc_delta_decoder
// PURPOSE
//   Receive end of the gp01 accumulator output stream {overflow, data[5:0]}.
//   Recovers each cycle's increment (0..14) by differencing consecutive samples,
//   checks it is in range, buffers it in a small FIFO and presents it on a
//   valid/ready interface to the downstream checker/logger.
// PARAMETERS
//   DATA_W     6   accumulator data width (overflow is one extra bit)
//   DELTA_W    4   width of a recovered increment
//   MAX_DELTA  14  largest legal increment (7+7); larger means protocol error
//   FIFO_DEPTH 4   entries in the output FIFO; power of two, >= 2
//   DROP_W     8   width of the saturating drop counter
// PORTS
//   clk            in   1        system clock, rising edge
//   i_rst_n        in   1        reset, asynchronous, active low
//   i_acc_data     in   DATA_W   accumulator data sample
//   i_acc_overflow in   1        accumulator carry for this sample
//   i_acc_valid    in   1        sample qualifier; low = no sample this cycle
//   i_clear        in   1        synchronous: leave ERROR, flush FIFO, go IDLE
//   o_delta        out  DELTA_W  head-of-FIFO increment
//   o_delta_valid  out  1        FIFO not empty
//   i_delta_ready  in   1        downstream accepts o_delta this cycle
//   o_err          out  1        sticky range error (state == ERROR)
//   o_drop_cnt     out  DROP_W   increments lost to FIFO full, saturating
// BEHAVIOUR
//   Reset (async assert, sync deassert at clk): state IDLE, FIFO empty,
//     o_delta=0, o_delta_valid=0, o_err=0, o_drop_cnt=0, reference=0.
//   Delta: d = {i_acc_overflow, i_acc_data} - {1'b0, ref}, DATA_W+1 bits, mod.
//     ref = i_acc_data of previous accepted sample (overflow bit never stored).
//   FSM:
//     IDLE : valid sample -> ref <= data, no push, -> TRACK.
//     TRACK: valid sample -> compute d; d <= MAX_DELTA -> push d[DELTA_W-1:0],
//            ref <= data; d > MAX_DELTA -> no push, -> ERROR. Zero deltas pushed.
//     ERROR: samples ignored, ref frozen, o_err=1; FIFO keeps draining.
//     i_clear (any state, highest priority): FIFO flushed, ref<=0, -> IDLE,
//       o_err=0; sample in the same cycle ignored. o_drop_cnt NOT cleared.
//   Latency: sample at edge N -> o_delta_valid at edge N+1 if FIFO was empty.
//   Handshake: pop when o_delta_valid && i_delta_ready; o_delta stable while
//     valid && !ready. i_delta_ready without valid is a no-op.
//   Full: push while full and no pop -> entry dropped, ref still updated,
//     o_drop_cnt += 1 (saturates at all-ones). Push+pop same cycle when full ->
//     both succeed, count unchanged. Push+pop when empty -> push only.
//   i_acc_valid low: no state change except pops.
// STRUCTURE
//   Package gp01_pkg: DATA_W, DELTA_W, MAX_DELTA constants; state enum
//     {ST_IDLE, ST_TRACK, ST_ERROR} as localparams (2-bit).
//   Sub-module gp01_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/flush,
//     async active-low reset); top holds FSM, differencer, drop counter.
// TESTING
//   1 Reset then samples 0,5,19,19,33 (ovf=0) -> no push for 0; pops 5,14,0,14.
//   2 ref=60, sample {ovf=1,data=4} -> delta 8 pushed; o_err stays 0.
//   3 ref=10, sample 30 -> d=20>14 -> o_err=1 next cycle, no push; further
//     samples ignored; i_clear -> o_err=0, IDLE, next sample only sets ref.
//   4 ready=0, 6 samples each +3 -> 4 entries held, o_drop_cnt=2; then ready=1
//     -> pops 3,3,3,3, o_delta_valid drops after 4th.
//   5 FIFO full, push+pop same cycle -> occupancy stays 4, drop_cnt unchanged;
//     ready toggled every cycle -> o_delta stable while stalled, order preserved.
//   6 Assert i_rst_n=0 mid-stream between edges -> outputs zero immediately;
//     FIFO empty, IDLE after release; drop_cnt 255 + one more drop stays 255.

Source files
------------

// File: rtl/gp01_pkg.sv
// gp01_pkg
//   Shared constants and the decoder state encoding for the receive end of the
//   gp01 accumulator stream.
package gp01_pkg;

    localparam int DATA_W    = 6;   // accumulator data width (overflow is one extra bit)
    localparam int DELTA_W   = 4;   // width of one recovered increment
    localparam int MAX_DELTA = 14;  // largest legal increment (7 + 7)

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no reference yet; next sample only seeds it
        ST_TRACK = 2'd1,  // differencing consecutive samples
        ST_ERROR = 2'd2   // sticky range error; samples ignored until clear
    } state_t;

endpackage

// File: rtl/gp01_sync_fifo.sv
// gp01_sync_fifo
//   Single-clock FIFO with first-word fall-through output.
//   Ports:
//     clk, rst_n       clock, asynchronous active-low reset
//     push, wdata      write request and data (ignored when full unless popping)
//     pop              read request (ignored when empty)
//     flush            synchronous empty, takes priority over push/pop
//     rdata            head entry, zero when empty
//     full, empty      occupancy flags
module gp01_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and an unreset array maps onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/gp01_acc_delta_decoder.sv
// gp01_acc_delta_decoder
//   Recovers per-cycle increments from the gp01 accumulator output stream by
//   differencing consecutive samples, flags out-of-range increments, and
//   buffers legal ones in a FIFO behind a valid/ready interface.
//   Ports:
//     clk, i_rst_n                      clock, asynchronous active-low reset
//     i_acc_data, i_acc_overflow        accumulator sample and its carry
//     i_acc_valid                       sample qualifier
//     i_clear                           leave ERROR, flush FIFO, return to IDLE
//     o_delta, o_delta_valid            head-of-FIFO increment and not-empty
//     i_delta_ready                     downstream accepts o_delta
//     o_err                             sticky range error
//     o_drop_cnt                        saturating count of increments lost to FIFO full
module gp01_acc_delta_decoder
    import gp01_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DROP_W     = 8
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [DATA_W-1:0]  i_acc_data,
    input  logic               i_acc_overflow,
    input  logic               i_acc_valid,
    input  logic               i_clear,
    output logic [DELTA_W-1:0] o_delta,
    output logic               o_delta_valid,
    input  logic               i_delta_ready,
    output logic               o_err,
    output logic [DROP_W-1:0]  o_drop_cnt
);

    localparam logic [DATA_W:0] MAX_D = (DATA_W+1)'(MAX_DELTA);

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   ref_q;
    logic [DATA_W-1:0]   ref_d;
    logic [DATA_W:0]     diff;
    logic                push;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop_ok;
    logic                drop;
    logic [DROP_W-1:0]   drop_cnt_q;

    // The carry restores the wrapped sample, so the modular difference is the
    // true increment whenever the accumulator advanced by less than 2^DATA_W.
    assign diff = {i_acc_overflow, i_acc_data} - {1'b0, ref_q};

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        push    = 1'b0;
        if (i_clear) begin
            state_d = ST_IDLE;
            ref_d   = '0;
        end else if (i_acc_valid) begin
            case (state_q)
                ST_IDLE: begin
                    ref_d   = i_acc_data;
                    state_d = ST_TRACK;
                end
                ST_TRACK: begin
                    if (diff <= MAX_D) begin
                        push  = 1'b1;
                        ref_d = i_acc_data;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
                default: ;  // ST_ERROR: samples ignored, reference frozen
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
        end
    end

    // A push into a full FIFO is lost unless a pop frees the slot this cycle;
    // the reference still advances so later deltas stay correct.
    assign pop_ok = i_delta_ready && !fifo_empty;
    assign drop   = push && fifo_full && !pop_ok;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    gp01_sync_fifo #(
        .WIDTH (DELTA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (i_rst_n),
        .push  (push),
        .wdata (diff[DELTA_W-1:0]),
        .pop   (i_delta_ready),
        .flush (i_clear),
        .rdata (o_delta),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign o_delta_valid = !fifo_empty;
    assign o_err         = (state_q == ST_ERROR);
    assign o_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_gp01_acc_delta_decoder.sv
// tb_gp01_acc_delta_decoder
//   Randomised and directed stimulus against a behavioural model; expected
//   increments go into a scoreboard queue that a negedge monitor consumes on
//   every DUT handshake.
module tb_gp01_acc_delta_decoder;

    logic       clk = 1'b0;
    logic       i_rst_n;
    logic [5:0] i_acc_data;
    logic       i_acc_overflow;
    logic       i_acc_valid;
    logic       i_clear;
    logic [3:0] o_delta;
    logic       o_delta_valid;
    logic       i_delta_ready;
    logic       o_err;
    logic [7:0] o_drop_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model: mode 0 = waiting for first sample, 1 = tracking, 2 = error.
    int exp_q[$];
    int m_mode = 0;
    int m_ref  = 0;
    int m_occ  = 0;
    int m_drop = 0;
    // Model values that the DUT outputs must show during the current cycle.
    int exp_level = 0;
    int exp_err   = 0;
    int exp_drop  = 0;
    int acc       = 0;

    bit have_stall = 1'b0;
    int stall_delta = 0;

    gp01_acc_delta_decoder dut (
        .clk            (clk),
        .i_rst_n        (i_rst_n),
        .i_acc_data     (i_acc_data),
        .i_acc_overflow (i_acc_overflow),
        .i_acc_valid    (i_acc_valid),
        .i_clear        (i_clear),
        .o_delta        (o_delta),
        .o_delta_valid  (o_delta_valid),
        .i_delta_ready  (i_delta_ready),
        .o_err          (o_err),
        .o_drop_cnt     (o_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: status flags every cycle, scoreboard pop on each handshake,
    // and stability of the head while the consumer stalls.
    always @(negedge clk) begin
        if (i_rst_n) begin
            check("delta_valid", int'(o_delta_valid), int'(exp_level != 0));
            check("err", int'(o_err), exp_err);
            check("drop_cnt", int'(o_drop_cnt), exp_drop);
            if (have_stall) check("stall_stable", int'(o_delta), stall_delta);
            if (o_delta_valid && i_delta_ready && !i_clear) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got %0d expected none at %0t", o_delta, $time);
                end else begin
                    check("delta", int'(o_delta), exp_q.pop_front());
                end
            end
            have_stall  = o_delta_valid && !i_delta_ready && !i_clear;
            stall_delta = int'(o_delta);
        end else begin
            have_stall = 1'b0;
        end
    end

    // One cycle of stimulus: drive inputs, record what the DUT must show this
    // cycle, then advance the model by this cycle's inputs.
    task automatic drive(input bit v, input int data, input bit ovf, input bit rdy, input bit clr);
        bit pop;
        int d;
        i_acc_valid    = v;
        i_acc_data     = data[5:0];
        i_acc_overflow = ovf;
        i_delta_ready  = rdy;
        i_clear        = clr;
        exp_level = m_occ;
        exp_err   = (m_mode == 2) ? 1 : 0;
        exp_drop  = m_drop;
        pop = rdy && (m_occ > 0);
        if (clr) begin
            m_mode = 0;
            m_ref  = 0;
            m_occ  = 0;
            exp_q.delete();
        end else begin
            if (pop) m_occ--;
            if (v) begin
                if (m_mode == 0) begin
                    m_ref  = data;
                    m_mode = 1;
                end else if (m_mode == 1) begin
                    d = (ovf ? 64 : 0) + data - m_ref;
                    if (d < 0) d += 128;
                    if (d <= 14) begin
                        if (m_occ < 4) begin
                            m_occ++;
                            exp_q.push_back(d);
                        end else if (m_drop < 255) begin
                            m_drop++;
                        end
                        m_ref = data;
                    end else begin
                        m_mode = 2;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic acc_sample(input int inc, input bit rdy);
        int s;
        s = acc + inc;
        drive(1'b1, s % 64, s >= 64, rdy, 1'b0);
        acc = s % 64;
    endtask

    task automatic set_ref(input int val, input bit rdy);
        drive(1'b1, val, 1'b0, rdy, 1'b0);
        acc = val;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) drive(1'b0, 0, 1'b0, rdy, 1'b0);
    endtask

    task automatic clear();
        drive(1'b0, 0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rst_n = 1'b0;
        i_acc_valid = 1'b0;
        i_acc_data = '0;
        i_acc_overflow = 1'b0;
        i_delta_ready = 1'b0;
        i_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_delta", int'(o_delta), 0);
        check("rst_valid", int'(o_delta_valid), 0);
        check("rst_err", int'(o_err), 0);
        check("rst_drop", int'(o_drop_cnt), 0);
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: first sample only seeds the reference; then 5, 14, 0, 14.
        set_ref(0, 1'b1);
        drive(1'b1, 5, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 19, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 19, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 33, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // 2: wrap through the carry: 60 -> {1,4} is +8.
        clear();
        set_ref(60, 1'b1);
        drive(1'b1, 4, 1'b1, 1'b1, 1'b0);
        acc = 4;
        idle(3, 1'b1);

        // 3: out-of-range increment, ignored samples, clear, reseed.
        clear();
        set_ref(10, 1'b1);
        drive(1'b1, 30, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 31, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 40, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        drive(1'b1, 50, 1'b0, 1'b1, 1'b1);
        set_ref(7, 1'b1);
        drive(1'b1, 9, 1'b0, 1'b1, 1'b0);
        acc = 9;
        idle(3, 1'b1);

        // 4: stalled consumer, six +3 samples: four held, two dropped.
        clear();
        set_ref(0, 1'b0);
        repeat (6) acc_sample(3, 1'b0);
        idle(6, 1'b1);

        // 5: full FIFO with simultaneous push+pop, then toggled ready.
        clear();
        set_ref(20, 1'b0);
        repeat (4) acc_sample(3, 1'b0);
        repeat (5) acc_sample(5, 1'b1);
        for (int i = 0; i < 10; i++) acc_sample(2 + i % 3, i[0]);
        for (int i = 0; i < 12; i++) idle(1, i[0]);

        // Randomised traffic, occasional illegal increments and clears.
        for (int i = 0; i < 400; i++) begin
            int inc;
            int s;
            bit clr;
            bit v;
            bit rdy;
            clr = ($urandom_range(0, 99) < 3);
            v   = ($urandom_range(0, 3) != 0);
            rdy = $urandom_range(0, 1) != 0;
            inc = ($urandom_range(0, 19) == 0) ? 15 + $urandom_range(0, 20) : $urandom_range(0, 14);
            if (v) begin
                s = acc + inc;
                drive(1'b1, s % 64, s >= 64, rdy, clr);
                acc = s % 64;
            end else begin
                drive(1'b0, $urandom_range(0, 63), $urandom_range(0, 1) != 0, rdy, clr);
            end
        end

        // 6: asynchronous reset between edges mid-stream.
        clear();
        set_ref(5, 1'b0);
        repeat (3) acc_sample(4, 1'b0);
        i_rst_n = 1'b0;
        #1;
        check("arst_delta", int'(o_delta), 0);
        check("arst_valid", int'(o_delta_valid), 0);
        check("arst_err", int'(o_err), 0);
        check("arst_drop", int'(o_drop_cnt), 0);
        m_mode = 0; m_ref = 0; m_occ = 0; m_drop = 0;
        exp_q.delete();
        exp_level = 0; exp_err = 0; exp_drop = 0;
        i_acc_valid = 1'b0;
        i_clear = 1'b0;
        i_delta_ready = 1'b0;
        @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturate the drop counter, then one more drop.
        set_ref(0, 1'b0);
        repeat (4) acc_sample(1, 1'b0);
        repeat (256) acc_sample(1, 1'b0);
        idle(8, 1'b1);
        check("drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
